alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Sequential front/back-end for the 8-bit combinational ALU (9-bit result, 4-bit sel).
//  Accepts operation requests over valid/ready and drives registered i1/i2/sel into the ALU.
//  Captures the 9-bit ALU output, derives status flags and presents the result over valid/ready.
//  Keeps an 8-bit accumulator so ops can chain on the previous result. Holds one op in flight.
// PARAMETERS
//  CNT_W   16   width of the completed-operation counter (wraps modulo 2^CNT_W)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  op_valid   in   1      request valid
//  op_ready   out  1      block can accept a request
//  op_a       in   8      operand A
//  op_b       in   8      operand B
//  op_sel     in   4      ALU opcode (all 16 codes legal)
//  op_use_acc in   1      1: use accumulator in place of op_a
//  alu_i1     out  8      to ALU i1, registered
//  alu_i2     out  8      to ALU i2, registered
//  alu_sel    out  4      to ALU sel, registered
//  alu_o      in   9      from ALU, combinational result
//  res_valid  out  1      result valid
//  res_ready  in   1      consumer accepts result
//  res_data   out  9      captured alu_o
//  res_zero   out  1      res_data[7:0]==0
//  res_carry  out  1      res_data[8] (carry / borrow / shifted-out bit)
//  res_neg    out  1      res_data[7]
//  res_ovf    out  1      signed overflow, add/sub only
//  acc        out  8      accumulator value
//  op_count   out  CNT_W  number of results handed off
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; alu_i1/i2/sel=0; res_*=0; res_valid=0; acc=0;
//   op_count=0; op_ready=0 while rst_n low, then 1 in IDLE.
//  FSM IDLE -> EXEC -> DONE -> IDLE.
//   IDLE: op_ready=1. On op_valid&op_ready at edge T0: alu_i1<=op_use_acc?acc:op_a,
//    alu_i2<=op_b, alu_sel<=op_sel, also latch the A/B sign bits for ovf; go EXEC.
//   EXEC: op_ready=0, res_valid=0. ALU settles combinationally. At edge T1: res_data<=alu_o,
//    flags computed from alu_o, acc<=alu_o[7:0]; go DONE.
//   DONE: res_valid=1, outputs stable. On res_valid&res_ready: op_count<=op_count+1
//    (wraps), go IDLE. No new op accepted in the handoff cycle (op_ready=0 in DONE).
//  Latency: res_valid high 2 edges after accept. Throughput: max 1 op per 3 cycles.
//  Overflow: sel 0000: ovf=(a7==b7)&&(r7!=a7); sel 0001: ovf=(a7!=b7)&&(r7!=a7);
//   all other sel: ovf=0. a=alu_i1, b=alu_i2, r=alu_o.
//  alu_i1/i2/sel hold their last values outside EXEC (no toggling when idle).
//  Backpressure: res_ready low holds DONE indefinitely; res_* and acc unchanged.
//  op_valid ignored outside IDLE; requester must hold it until op_ready.
//  res_ready ignored when res_valid=0.
//  Reset mid-operation (EXEC or DONE): op discarded, no count increment, acc=0.
//  op_use_acc after reset uses acc=0.
// TESTING
//  1 add 0xFF+0x01 sel=0000 -> res_data=0x100, zero=1, carry=1, neg=0, ovf=0, valid 2 edges after accept.
//  2 sub 0x05-0x07 sel=0001 -> res_data=0x1FE, carry=1, neg=1, zero=0, ovf=0.
//  3 add 0x7F+0x01 -> res_data=0x080, neg=1, ovf=1; sub 0x80-0x01 -> 0x07F, ovf=1.
//  4 chain: add 0x10+0x20 (acc=0x30), then use_acc=1 sel=0000 b=0x05 -> res 0x035;
//    then use_acc=1 sel=1110 -> rotate 0x35 -> 0x04D.
//  5 backpressure: res_ready=0 for 5 cycles -> res_valid=1, res_data stable, op_ready=0,
//    op_count unchanged; release -> op_count+1, op_ready=1 next cycle.
//  6 rst_n low during EXEC -> all outputs 0 immediately; op_count=0; next op works normally;
//    count wrap at CNT_W=2 after 4 ops -> 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequential front/back-end for an external 8-bit combinational ALU (9-bit result, 4-bit sel).
//   Accepts one operation over a valid/ready request port and drives registered operands and
//   opcode into the ALU. One cycle later it captures the ALU output and derives status flags.
//   It then presents the result over a valid/ready result port. An 8-bit accumulator lets an op
//   use the previous result in place of operand A. Only one op is in flight at a time.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   i_op_valid/o_op_ready request handshake; fields i_op_a, i_op_b, i_op_sel, i_op_use_acc
//   o_alu_i1/i2/sel       registered operands/opcode to the ALU
//   i_alu_o               combinational ALU result
//   o_res_valid/i_res_ready result handshake; o_res_data plus zero/carry/neg/ovf flags
//   o_acc                 accumulator (low 8 bits of the last captured result)
//   o_op_count            number of results handed off, wraps modulo 2^CNT_W
module alu_issue_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [7:0]       i_op_a,
  input  logic [7:0]       i_op_b,
  input  logic [3:0]       i_op_sel,
  input  logic             i_op_use_acc,
  output logic [7:0]       o_alu_i1,
  output logic [7:0]       o_alu_i2,
  output logic [3:0]       o_alu_sel,
  input  logic [8:0]       i_alu_o,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [8:0]       o_res_data,
  output logic             o_res_zero,
  output logic             o_res_carry,
  output logic             o_res_neg,
  output logic             o_res_ovf,
  output logic [7:0]       o_acc,
  output logic [CNT_W-1:0] o_op_count
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             w_accept;
  logic             w_capture;
  logic             w_handoff;
  logic             w_ovf;

  logic [7:0]       r_alu_i1;
  logic [7:0]       r_alu_i2;
  logic [3:0]       r_alu_sel;
  logic [8:0]       r_res_data;
  logic             r_res_zero;
  logic             r_res_carry;
  logic             r_res_neg;
  logic             r_res_ovf;
  logic [7:0]       r_acc;
  logic [CNT_W-1:0] r_op_count;

  // Next-state and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_handoff    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_op_valid) begin
          w_accept     = 1'b1;
          w_state_next = StExec;
        end
      end
      StExec: begin
        w_capture    = 1'b1;
        w_state_next = StDone;
      end
      StDone: begin
        if (i_res_ready) begin
          w_handoff    = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Signed overflow for add/sub only. The operand sign bits are taken from the operand
  // registers, which hold the accepted A/B values for the whole operation.
  always_comb begin
    w_ovf = 1'b0;
    case (r_alu_sel)
      4'b0000: w_ovf = (r_alu_i1[7] == r_alu_i2[7]) && (i_alu_o[7] != r_alu_i1[7]);
      4'b0001: w_ovf = (r_alu_i1[7] != r_alu_i2[7]) && (i_alu_o[7] != r_alu_i1[7]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand registers only load on accept so the ALU inputs stay quiet otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_i1  <= 8'h00;
      r_alu_i2  <= 8'h00;
      r_alu_sel <= 4'h0;
    end else if (w_accept) begin
      r_alu_i1  <= i_op_use_acc ? r_acc : i_op_a;
      r_alu_i2  <= i_op_b;
      r_alu_sel <= i_op_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data  <= 9'h000;
      r_res_zero  <= 1'b0;
      r_res_carry <= 1'b0;
      r_res_neg   <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_acc       <= 8'h00;
    end else if (w_capture) begin
      r_res_data  <= i_alu_o;
      r_res_zero  <= (i_alu_o[7:0] == 8'h00);
      r_res_carry <= i_alu_o[8];
      r_res_neg   <= i_alu_o[7];
      r_res_ovf   <= w_ovf;
      r_acc       <= i_alu_o[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_handoff) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  // Ready is gated by reset so it reads low while rst_n is held, even though the state is Idle.
  assign o_op_ready  = (r_state == StIdle) && rst_n;
  assign o_res_valid = (r_state == StDone);
  assign o_alu_i1    = r_alu_i1;
  assign o_alu_i2    = r_alu_i2;
  assign o_alu_sel   = r_alu_sel;
  assign o_res_data  = r_res_data;
  assign o_res_zero  = r_res_zero;
  assign o_res_carry = r_res_carry;
  assign o_res_neg   = r_res_neg;
  assign o_res_ovf   = r_res_ovf;
  assign o_acc       = r_acc;
  assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: bench-side ALU model, queue scoreboard, random plus directed ops.
module tb_alu_issue_ctrl;

  localparam int unsigned CntW = 2;

  logic            clk;
  logic            rst_n;
  logic            op_valid;
  logic            op_ready;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic [3:0]      op_sel;
  logic            op_use_acc;
  logic [7:0]      alu_i1;
  logic [7:0]      alu_i2;
  logic [3:0]      alu_sel;
  logic [8:0]      alu_o;
  logic            res_valid;
  logic            res_ready;
  logic [8:0]      res_data;
  logic            res_zero;
  logic            res_carry;
  logic            res_neg;
  logic            res_ovf;
  logic [7:0]      acc;
  logic [CntW-1:0] op_count;

  typedef struct {
    logic [8:0] data;
    logic       zero;
    logic       carry;
    logic       neg;
    logic       ovf;
    logic [7:0] acc;
    logic       has_gold;
    logic [8:0] gold;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              failures = 0;
  logic [7:0]      m_acc = 8'h00;
  logic [CntW-1:0] exp_count = '0;
  logic            seen = 1'b0;
  logic            pend = 1'b0;
  logic [8:0]      cur_data = 9'h000;
  logic            stall_req = 1'b0;
  logic            rand_mode = 1'b0;

  // Bench-owned ALU: add/sub produce a 9-bit result whose top bit is carry/borrow.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] sel);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r;
    case (sel)
      4'h0: r = ua + ub;
      4'h1: r = (ua - ub) & 32'h1FF;
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: r = ua ^ ub;
      4'h5: r = (~ua) & 32'hFF;
      4'h6: r = ua * 2;
      4'h7: r = ((ua % 2) * 256) + (ua / 2);
      4'h8: r = (~(ua & ub)) & 32'hFF;
      4'h9: r = (~(ua | ub)) & 32'hFF;
      4'hA: r = (~(ua ^ ub)) & 32'hFF;
      4'hB: r = (ua * ub) & 32'hFF;
      4'hC: r = ua + 1;
      4'hD: r = (ua - 1) & 32'h1FF;
      4'hE: r = ((ua % 4) * 64) + (ua / 4);  // rotate right by two
      default: r = ub;
    endcase
    return r[8:0];
  endfunction

  assign alu_o = alu_f(alu_i1, alu_i2, alu_sel);

  alu_issue_ctrl #(
    .CNT_W(CntW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_op_valid  (op_valid),
    .o_op_ready  (op_ready),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_op_sel    (op_sel),
    .i_op_use_acc(op_use_acc),
    .o_alu_i1    (alu_i1),
    .o_alu_i2    (alu_i2),
    .o_alu_sel   (alu_sel),
    .i_alu_o     (alu_o),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_res_zero  (res_zero),
    .o_res_carry (res_carry),
    .o_res_neg   (res_neg),
    .o_res_ovf   (res_ovf),
    .o_acc       (acc),
    .o_op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Consumer: ready changes just after the rising edge so the monitor sees it stable.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = stall_req ? 1'b0 : (rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Monitor: pops one expectation per presented result and tracks handoffs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      seen      = 1'b0;
      pend      = 1'b0;
      exp_count = '0;
    end else begin
      if (pend) begin
        chk("count_after_handoff", 32'(op_count), 32'(exp_count));
        chk("ready_after_handoff", 32'(op_ready), 32'd1);
        pend = 1'b0;
      end
      if (res_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%0h required=none", res_data);
          end else begin
            e = q.pop_front();
            chk("res_data", 32'(res_data), 32'(e.data));
            chk("res_zero", 32'(res_zero), 32'(e.zero));
            chk("res_carry", 32'(res_carry), 32'(e.carry));
            chk("res_neg", 32'(res_neg), 32'(e.neg));
            chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
            chk("acc", 32'(acc), 32'(e.acc));
            if (e.has_gold) chk("golden_vector", 32'(res_data), 32'(e.gold));
            cur_data = e.data;
          end
          seen = 1'b1;
        end else begin
          chk("hold_data", 32'(res_data), 32'(cur_data));
        end
        chk("ready_low_in_done", 32'(op_ready), 32'd0);
        if (res_ready) begin
          exp_count = exp_count + 1'b1;
          pend      = 1'b1;
          seen      = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                       input logic use_acc, input logic has_gold, input logic [8:0] gold);
    int         waitc = 0;
    logic [7:0] ae;
    logic [8:0] r;
    exp_t       e;
    @(negedge clk);
    op_valid   = 1'b1;
    op_a       = a;
    op_b       = b;
    op_sel     = sel;
    op_use_acc = use_acc;
    while (!op_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!op_ready) begin
      chk("accept_timeout", 32'(op_ready), 32'd1);
      op_valid = 1'b0;
      return;
    end
    // Reference: operand A is the accumulator when requested, then the ALU rule applies.
    ae         = use_acc ? m_acc : a;
    r          = alu_f(ae, b, sel);
    e.data     = r;
    e.zero     = (r[7:0] == 8'h00);
    e.carry    = r[8];
    e.neg      = r[7];
    e.ovf      = (sel == 4'h0) ? ((ae[7] == b[7]) && (r[7] != ae[7])) :
                 (sel == 4'h1) ? ((ae[7] != b[7]) && (r[7] != ae[7])) : 1'b0;
    e.acc      = r[7:0];
    e.has_gold = has_gold;
    e.gold     = gold;
    m_acc      = r[7:0];
    q.push_back(e);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_a     = 8'($urandom);
    @(negedge clk);
    chk("exec_valid_low", 32'(res_valid), 32'd0);
    chk("exec_ready_low", 32'(op_ready), 32'd0);
    @(negedge clk);
    chk("valid_two_edges", 32'(res_valid), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    op_valid   = 1'b0;
    op_a       = 8'h00;
    op_b       = 8'h00;
    op_sel     = 4'h0;
    op_use_acc = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rst_ready", 32'(op_ready), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_alu", {8'h00, alu_i1, alu_i2, 4'h0, alu_sel}, 32'd0);
    chk("rst_res", {res_data, res_zero, res_carry, res_neg, res_ovf}, 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(op_ready), 32'd1);

    // Directed vectors.
    issue(8'hFF, 8'h01, 4'h0, 1'b0, 1'b1, 9'h100);
    issue(8'h05, 8'h07, 4'h1, 1'b0, 1'b1, 9'h1FE);
    issue(8'h7F, 8'h01, 4'h0, 1'b0, 1'b1, 9'h080);
    issue(8'h80, 8'h01, 4'h1, 1'b0, 1'b1, 9'h07F);
    issue(8'h10, 8'h20, 4'h0, 1'b0, 1'b1, 9'h030);
    issue(8'hC3, 8'h05, 4'h0, 1'b1, 1'b1, 9'h035);
    issue(8'h99, 8'h00, 4'hE, 1'b1, 1'b1, 9'h04D);

    // Backpressure: hold the result for five cycles.
    stall_req = 1'b1;
    issue(8'h12, 8'h34, 4'h4, 1'b0, 1'b0, 9'h000);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_count", 32'(op_count), 32'(exp_count));
    end
    stall_req = 1'b0;

    // Random ops with random consumer backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 8'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 9'h000);
    end
    rand_mode = 1'b0;

    // Reset while the op is in EXEC.
    @(negedge clk);
    op_valid = 1'b1;
    op_a     = 8'h5A;
    op_b     = 8'h11;
    op_sel   = 4'h0;
    waitc    = 0;
    while (!op_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    chk("rst_test_accept", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("rst_test_in_exec", 32'(res_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(op_ready), 32'd0);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_alu", {8'h00, alu_i1, alu_i2, 4'h0, alu_sel}, 32'd0);
    chk("midrst_res", {res_data, res_zero, res_carry, res_neg, res_ovf}, 32'd0);
    chk("midrst_acc", 32'(acc), 32'd0);
    chk("midrst_count", 32'(op_count), 32'd0);
    m_acc = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Accumulator starts at zero; four handoffs wrap the 2-bit count back to zero.
    issue(8'hAA, 8'h12, 4'h0, 1'b1, 1'b1, 9'h012);
    issue(8'h01, 8'h02, 4'h3, 1'b0, 1'b1, 9'h003);
    issue(8'h0F, 8'hF0, 4'h2, 1'b0, 1'b1, 9'h000);
    issue(8'h00, 8'h01, 4'h1, 1'b0, 1'b1, 9'h1FF);
    repeat (3) @(negedge clk);
    chk("count_wrap", 32'(op_count), 32'd0);

    waitc = 0;
    while ((q.size() != 0 || res_valid) && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
